pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central freeze/flush scheduler for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- Drives the freeze and flush inputs of the PC register and of every stage register (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Tracks the destination registers of the instructions in EXE and MEM with a private scoreboard and detects RAW hazards against the instruction in ID.
- Sequences branch flushes and a memory-wait state machine that stalls on a slow data memory (SRAM handshake).

Parameters:
- FORWARDING_EN, 0, when 1 stall only on load-use; when 0 stall on any RAW hit in EXE or MEM.
- REG_W, 4, register-index width.
- MAX_WAIT, 255, memory-wait cycles tolerated before timeout_err sets.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_src1  in  REG_W  ID source register 1
- id_src2  in  REG_W  ID source register 2
- id_use_src1  in  1  src1 is read
- id_use_src2  in  1  src2 is read
- id_dest  in  REG_W  ID destination register
- id_wb_en  in  1  ID instruction writes back
- id_mem_read  in  1  ID instruction is a load
- branch_taken  in  1  EXE resolved a taken branch this cycle
- mem_req  in  1  MEM stage has an access in flight
- mem_ready  in  1  data memory completes the access this cycle
- pc_freeze  out  1  hold PC
- if_id_freeze  out  1  hold IF/ID register
- if_id_flush  out  1  clear IF/ID register
- id_exe_flush  out  1  insert bubble into ID/EXE register
- back_freeze  out  1  hold ID/EXE, EXE/MEM and MEM/WB registers
- hazard  out  1  RAW stall this cycle (debug)
- timeout_err  out  1  sticky; memory wait exceeded MAX_WAIT
- stall_cnt  out  CNT_W  saturating count of cycles with pc_freeze=1

Behaviour:
- Reset (async, any time, including mid-wait):
  - state=RUN; scoreboard entries invalid; wait counter=0; timeout_err=0; stall_cnt=0.
  - All freeze/flush outputs are 0 while rst is high.
- Scoreboard: two entries, EXE {dest, wb_en, mem_read} and MEM {dest, wb_en}. Update at posedge:
  - mem_stall: both entries hold.
  - else: MEM<=EXE; EXE<=bubble (wb_en=0) if id_exe_flush, else the ID fields.
- RAW hit:
  - hitE = EXE.wb_en & ((id_use_src1 & src1==EXE.dest) | (id_use_src2 & src2==EXE.dest)).
  - hitM is the same comparison against the MEM entry.
- Hazard rule:
  - FORWARDING_EN=0: hazard = hitE | hitM.
  - FORWARDING_EN=1: hazard = hitE & EXE.mem_read.
- mem_stall is combinational: (state==RUN & mem_req & ~mem_ready) | (state==WAIT & ~mem_ready).
- FSM:
  - RUN -> WAIT on mem_req & ~mem_ready.
  - WAIT -> RUN on mem_ready.
  - The wait counter increments every WAIT cycle and clears on entering RUN.
  - The counter reaching MAX_WAIT sets timeout_err; it stays set until rst. The FSM keeps waiting.
- Output priority, all combinational from current inputs/state, zero latency:
  1. mem_stall: pc_freeze=if_id_freeze=back_freeze=1; all flushes=0. A branch_taken arriving during the stall is deferred, because EXE is held and branch_taken stays asserted.
  2. branch_taken: if_id_flush=1, id_exe_flush=1, no freezes. Branch beats hazard in the same cycle.
  3. hazard: pc_freeze=1, if_id_freeze=1, id_exe_flush=1 (one bubble per cycle until the hit clears).
  4. Otherwise all outputs are 0.
- hazard output reflects the raw hazard term even when masked by priority 1 or 2.
- stall_cnt increments each cycle pc_freeze=1 and saturates at all-ones.
- Register 0 is not special: comparisons are exact.

Decomposition:
- Shared defines file: REG_W, state encodings (RUN=1'b0, WAIT=1'b1), bubble encoding.
- One sub-module, hazard_scoreboard: holds the two scoreboard entries plus the hit/hazard logic.
- The top level holds the FSM, the wait counter, the output priority logic and the performance counter.

Test Plan:
- FORWARDING_EN=0, EXE={dest=3,wb_en=1}, ID src1=3 use=1 -> hazard=1, pc_freeze=1, if_id_freeze=1, id_exe_flush=1. Next cycle EXE is a bubble, MEM.dest=3, hazard stays 1. The cycle after, hazard=0.
- FORWARDING_EN=1, same stream with EXE not a load -> no stall. With EXE.mem_read=1 -> exactly one bubble cycle, then pc_freeze=0.
- branch_taken=1 together with an active hazard -> if_id_flush=1, id_exe_flush=1, pc_freeze=0. Next cycle EXE entry is a bubble.
- mem_req=1, mem_ready=0 for 4 cycles then 1 -> back_freeze=1 for exactly 4 cycles. state returns to RUN. stall_cnt=4. Scoreboard is unchanged across the wait.
- MAX_WAIT=3, mem_ready held 0 -> timeout_err rises after the 3rd WAIT cycle and stays 1 after mem_ready. Asserting rst mid-wait -> all outputs 0 and state=RUN immediately, without waiting for a clock edge.
- branch_taken=1 during a memory wait -> no flush while stalled. Flush asserts in the first cycle mem_ready=1 allows progress.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline freeze/flush scheduler.
// Holds default widths, memory-wait state encoding and the scoreboard bubble encoding.
package pipeline_hazard_ctrl_pkg;

    localparam int DEFAULT_REG_W    = 4;
    localparam int DEFAULT_MAX_WAIT = 255;
    localparam int DEFAULT_CNT_W    = 32;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // A scoreboard entry carrying these flags never produces a RAW hit.
    localparam logic BUBBLE_WB_EN    = 1'b0;
    localparam logic BUBBLE_MEM_READ = 1'b0;

    function automatic logic src_hit(input logic use1, input logic eq1,
                                     input logic use2, input logic eq2);
        return (use1 & eq1) | (use2 & eq2);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The pipeline side uses the master modport, the controller the slave modport.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 4
);
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_use_src1;
    logic             id_use_src2;
    logic [REG_W-1:0] id_dest;
    logic             id_wb_en;
    logic             id_mem_read;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_freeze;
    logic             if_id_freeze;
    logic             if_id_flush;
    logic             id_exe_flush;
    logic             back_freeze;
    logic             hazard;

    modport master (
        output id_src1, id_src2, id_use_src1, id_use_src2, id_dest,
               id_wb_en, id_mem_read, branch_taken, mem_req, mem_ready,
        input  pc_freeze, if_id_freeze, if_id_flush, id_exe_flush,
               back_freeze, hazard
    );

    modport slave (
        input  id_src1, id_src2, id_use_src1, id_use_src2, id_dest,
               id_wb_en, id_mem_read, branch_taken, mem_req, mem_ready,
        output pc_freeze, if_id_freeze, if_id_flush, id_exe_flush,
               back_freeze, hazard
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_scoreboard.sv
// Private copy of the EXE and MEM destination registers, used to detect RAW
// hazards against the instruction currently sitting in ID.
module hazard_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FORWARDING_EN = 0,
    parameter int REG_W         = DEFAULT_REG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    input  logic             mem_stall,
    input  logic             id_exe_flush,
    output logic             hazard
);

    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_read;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic             hit_exe;
    logic             hit_mem;

    // Entries shadow the real stage registers: they hold while memory stalls
    // and take a bubble whenever the ID/EXE register is flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_dest     <= '0;
            exe_wb_en    <= BUBBLE_WB_EN;
            exe_mem_read <= BUBBLE_MEM_READ;
            mem_dest     <= '0;
            mem_wb_en    <= BUBBLE_WB_EN;
        end else if (!mem_stall) begin
            mem_dest  <= exe_dest;
            mem_wb_en <= exe_wb_en;
            if (id_exe_flush) begin
                exe_dest     <= '0;
                exe_wb_en    <= BUBBLE_WB_EN;
                exe_mem_read <= BUBBLE_MEM_READ;
            end else begin
                exe_dest     <= id_dest;
                exe_wb_en    <= id_wb_en;
                exe_mem_read <= id_mem_read;
            end
        end
    end

    always_comb begin
        hit_exe = exe_wb_en & src_hit(id_use_src1, id_src1 == exe_dest,
                                      id_use_src2, id_src2 == exe_dest);
        hit_mem = mem_wb_en & src_hit(id_use_src1, id_src1 == mem_dest,
                                      id_use_src2, id_src2 == mem_dest);
    end

    // With forwarding only a load in EXE cannot supply its result in time.
    generate
        if (FORWARDING_EN != 0) begin : g_fwd
            assign hazard = hit_exe & exe_mem_read;
        end else begin : g_nofwd
            assign hazard = hit_exe | hit_mem;
        end
    endgenerate

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central freeze/flush scheduler for the 5-stage pipeline: memory-wait FSM,
// branch flush sequencing, RAW stall insertion and a stall performance counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FORWARDING_EN = 0,
    parameter int REG_W         = DEFAULT_REG_W,
    parameter int MAX_WAIT      = DEFAULT_MAX_WAIT,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus,
    output logic                  timeout_err,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int                WAIT_W     = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W:0]   MAX_WAIT_V = MAX_WAIT[WAIT_W:0];

    mem_state_e        state;
    mem_state_e        state_next;
    logic              mem_stall;
    logic              hazard_raw;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W:0]   wait_inc;

    logic pc_freeze;
    logic if_id_freeze;
    logic if_id_flush;
    logic id_exe_flush;
    logic back_freeze;

    hazard_scoreboard #(
        .FORWARDING_EN (FORWARDING_EN),
        .REG_W         (REG_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .id_src1      (bus.id_src1),
        .id_src2      (bus.id_src2),
        .id_use_src1  (bus.id_use_src1),
        .id_use_src2  (bus.id_use_src2),
        .id_dest      (bus.id_dest),
        .id_wb_en     (bus.id_wb_en),
        .id_mem_read  (bus.id_mem_read),
        .mem_stall    (mem_stall),
        .id_exe_flush (id_exe_flush),
        .hazard       (hazard_raw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // The stall is visible in the very cycle the slow access starts, before WAIT is entered.
    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        case (state)
            ST_RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    state_next = ST_WAIT;
                    mem_stall  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.mem_ready) begin
                    state_next = ST_RUN;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign wait_inc = {1'b0, wait_cnt} + 1'b1;

    // The timeout flag is sticky; the FSM keeps waiting for the memory regardless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (state == ST_WAIT) begin
            if (wait_inc >= MAX_WAIT_V) begin
                timeout_err <= 1'b1;
            end
            if (bus.mem_ready) begin
                wait_cnt <= '0;
            end else if (wait_inc >= MAX_WAIT_V) begin
                wait_cnt <= MAX_WAIT_V[WAIT_W-1:0];
            end else begin
                wait_cnt <= wait_inc[WAIT_W-1:0];
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // A branch seen during a memory stall stays asserted because EXE is held,
    // so it is simply serviced once the stall releases.
    always_comb begin
        pc_freeze    = 1'b0;
        if_id_freeze = 1'b0;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        back_freeze  = 1'b0;
        if (rst) begin
            pc_freeze = 1'b0;
        end else if (mem_stall) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            back_freeze  = 1'b1;
        end else if (bus.branch_taken) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else if (hazard_raw) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            id_exe_flush = 1'b1;
        end
    end

    assign bus.pc_freeze    = pc_freeze;
    assign bus.if_id_freeze = if_id_freeze;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_exe_flush = id_exe_flush;
    assign bus.back_freeze  = back_freeze;
    assign bus.hazard       = hazard_raw & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (pc_freeze && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
